// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Free-running VGA raster timing source. Divides the system clock down to
//   the pixel rate, walks a horizontal/vertical pixel position through the
//   whole frame (visible area plus porches and sync), and produces the sync,
//   blanking and line/frame start markers that overlay and colour-mux logic
//   key off.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   o_pix_en       one-clock strobe per pixel period
//   o_H_Cont       horizontal position, 0..H_TOTAL-1 (0..H_ACT-1 visible)
//   o_V_Cont       vertical position,   0..V_TOTAL-1 (0..V_ACT-1 visible)
//   o_hsync        horizontal sync, active level SYNC_POL
//   o_vsync        vertical sync, active level SYNC_POL
//   o_active       1 while (H,V) lies inside the visible area
//   o_blank_n      DAC blank, identical to o_active
//   o_line_start   one-clock pulse when o_H_Cont becomes 0
//   o_frame_start  one-clock pulse when (o_H_Cont,o_V_Cont) becomes (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACT    = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACT    = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_pix_en,
    output logic [12:0] o_H_Cont,
    output logic [12:0] o_V_Cont,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_active,
    output logic        o_blank_n,
    output logic        o_line_start,
    output logic        o_frame_start
);

    // A one-clock divider still needs a one-bit register so the width never
    // collapses to zero.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [12:0] H_LAST       = 13'(H_ACT + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [12:0] V_LAST       = 13'(V_ACT + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [12:0] H_ACT_W      = 13'(H_ACT);
    localparam logic [12:0] V_ACT_W      = 13'(V_ACT);
    localparam logic [12:0] H_SYNC_START = 13'(H_ACT + H_FRONT);
    localparam logic [12:0] H_SYNC_END   = 13'(H_ACT + H_FRONT + H_SYNC);
    localparam logic [12:0] V_SYNC_START = 13'(V_ACT + V_FRONT);
    localparam logic [12:0] V_SYNC_END   = 13'(V_ACT + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick;
    logic [12:0]      h_q, h_d;
    logic [12:0]      v_q, v_d;
    logic             pix_en_q;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next-state logic. Every registered output is derived from the
    // next-state counters so that sync, blanking and the start pulses land
    // in the same clock as the counter value they describe.
    always_comb begin
        pix_tick = (div_q == DIV_LAST);
        div_d    = pix_tick ? '0 : div_q + 1'b1;

        h_d = h_q;
        v_d = v_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                // Vertical advances only on the horizontal wrap, so vsync
                // always changes on whole-line boundaries.
                v_d = (v_q == V_LAST) ? '0 : v_q + 13'd1;
            end else begin
                h_d = h_q + 13'd1;
            end
        end

        hsync_d       = ((h_d >= H_SYNC_START) && (h_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_d >= V_SYNC_START) && (v_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        active_d      = (h_d < H_ACT_W) && (v_d < V_ACT_W);
        line_start_d  = pix_tick && (h_d == 13'd0);
        frame_start_d = line_start_d && (v_d == 13'd0);
    end

    // State and output registers. Reset parks the position on the last pixel
    // of the frame so the first pixel strobe after release wraps cleanly to
    // (0,0) and raises both start pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            pix_en_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_en_q      <= pix_tick;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_pix_en      = pix_en_q;
    assign o_H_Cont      = h_q;
    assign o_V_Cont      = v_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_active      = active_q;
    assign o_blank_n     = active_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose:
//   Drives three vga_timing_gen instances (default 640x480 timing, a tiny
//   one-clock-per-pixel raster with active-high sync, and a tiny divide-by-3
//   raster) from a shared clock and reset. Expected outputs come from a
//   position-from-elapsed-clocks model of the raster.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic [12:0] h;
        logic [12:0] v;
        logic        pe;
        logic        hs;
        logic        vs;
        logic        act;
        logic        bn;
        logic        ls;
        logic        fs;
    } obsT;

    typedef struct {
        int cd, ha, hf, hsw, hb, va, vf, vsw, vb;
        bit pol;
    } cfgT;

    typedef struct {
        int  n;
        obsT exp;
    } vecT;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;
    cfgT  cfg0, cfg1, cfg2;
    obsT  obs0, obs1, obs2;

    logic [12:0] h0, v0, h1, v1, h2, v2;
    logic pe0, hs0, vs0, act0, bn0, ls0, fs0;
    logic pe1, hs1, vs1, act1, bn1, ls1, fs1;
    logic pe2, hs2, vs2, act2, bn2, ls2, fs2;

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .i_clk(clk), .i_rst_n(rstN), .o_pix_en(pe0), .o_H_Cont(h0), .o_V_Cont(v0),
        .o_hsync(hs0), .o_vsync(vs0), .o_active(act0), .o_blank_n(bn0),
        .o_line_start(ls0), .o_frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_ACT(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .o_pix_en(pe1), .o_H_Cont(h1), .o_V_Cont(v1),
        .o_hsync(hs1), .o_vsync(vs1), .o_active(act1), .o_blank_n(bn1),
        .o_line_start(ls1), .o_frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACT(5), .H_FRONT(2), .H_SYNC(2), .H_BACK(3),
        .V_ACT(3), .V_FRONT(2), .V_SYNC(1), .V_BACK(2), .SYNC_POL(1'b0)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rstN), .o_pix_en(pe2), .o_H_Cont(h2), .o_V_Cont(v2),
        .o_hsync(hs2), .o_vsync(vs2), .o_active(act2), .o_blank_n(bn2),
        .o_line_start(ls2), .o_frame_start(fs2)
    );

    assign obs0 = {h0, v0, pe0, hs0, vs0, act0, bn0, ls0, fs0};
    assign obs1 = {h1, v1, pe1, hs1, vs1, act1, bn1, ls1, fs1};
    assign obs2 = {h2, v2, pe2, hs2, vs2, act2, bn2, ls2, fs2};

    // Clocks elapsed since reset release; the model turns this into a raster
    // position with plain division and remainder.
    always @(posedge clk) n <= rstN ? n + 1 : 0;

    function automatic obsT refModel(cfgT c, bit inReset, int clocks);
        obsT r;
        int ht, vt, pix, pos, hh, vv;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        r.h = 13'(ht - 1);
        r.v = 13'(vt - 1);
        r.pe = 1'b0; r.hs = ~c.pol; r.vs = ~c.pol;
        r.act = 1'b0; r.bn = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
        if (inReset || clocks < c.cd) return r;
        pix = clocks / c.cd - 1;
        pos = pix % (ht * vt);
        hh  = pos % ht;
        vv  = pos / ht;
        r.h   = 13'(hh);
        r.v   = 13'(vv);
        r.pe  = (clocks % c.cd) == 0;
        r.hs  = (hh >= c.ha + c.hf && hh < c.ha + c.hf + c.hsw) ? c.pol : ~c.pol;
        r.vs  = (vv >= c.va + c.vf && vv < c.va + c.vf + c.vsw) ? c.pol : ~c.pol;
        r.act = (hh < c.ha) && (vv < c.va);
        r.bn  = r.act;
        r.ls  = r.pe && (hh == 0);
        r.fs  = r.ls && (vv == 0);
        return r;
    endfunction

    function automatic string fmtObs(obsT o);
        return $sformatf("H=%0d V=%0d pe=%0b hs=%0b vs=%0b act=%0b bn=%0b ls=%0b fs=%0b",
                         o.h, o.v, o.pe, o.hs, o.vs, o.act, o.bn, o.ls, o.fs);
    endfunction

    task automatic checkOutput(input string name, input obsT actual, input obsT expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %s, expected %s", name, $time,
                     fmtObs(actual), fmtObs(expected));
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Continuous comparison of all instances against the model.
    always @(negedge clk) begin
        checkOutput("model_dut0", obs0, refModel(cfg0, !rstN, n));
        checkOutput("model_dut1", obs1, refModel(cfg1, !rstN, n));
        checkOutput("model_dut2", obs2, refModel(cfg2, !rstN, n));
    end

    // Asynchronous reset at a given offset after a clock edge, checked
    // immediately without any clock, held for a number of clocks, released
    // between edges, then left free-running.
    task automatic applyStimulus(input int offset, input int holdClocks, input int runClocks);
        @(posedge clk);
        #(offset);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_dut0", obs0, refModel(cfg0, 1'b1, 0));
        checkOutput("async_reset_dut1", obs1, refModel(cfg1, 1'b1, 0));
        checkOutput("async_reset_dut2", obs2, refModel(cfg2, 1'b1, 0));
        repeat (holdClocks) @(posedge clk);
        @(negedge clk);
        #2;
        rstN = 1'b1;
        repeat (runClocks) @(negedge clk);
    endtask

    task automatic waitClocks(input int target, input string name);
        int guard;
        guard = 0;
        while (n < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) checkValue(name, n, target);
    endtask

    function automatic vecT mk(int nn, int hh, int vv, bit pe, bit hs, bit vs, bit act,
                               bit ls, bit fs);
        vecT r;
        r.n   = nn;
        r.exp = {13'(hh), 13'(vv), pe, hs, vs, act, act, ls, fs};
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecT vecs[14];
        int offsets[6];
        int t0, cnt, guard;

        cfg0 = '{cd: 2, ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33, pol: 1'b0};
        cfg1 = '{cd: 1, ha: 8, hf: 2, hsw: 3, hb: 1, va: 4, vf: 1, vsw: 1, vb: 1, pol: 1'b1};
        cfg2 = '{cd: 3, ha: 5, hf: 2, hsw: 2, hb: 3, va: 3, vf: 2, vsw: 1, vb: 2, pol: 1'b0};

        // Hand-derived checkpoints for the default timing, indexed by clocks
        // since release.
        vecs[0]  = mk(0,    799, 524, 0, 1, 1, 0, 0, 0);
        vecs[1]  = mk(1,    799, 524, 0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(2,    0,   0,   1, 1, 1, 1, 1, 1);
        vecs[3]  = mk(3,    0,   0,   0, 1, 1, 1, 0, 0);
        vecs[4]  = mk(4,    1,   0,   1, 1, 1, 1, 0, 0);
        vecs[5]  = mk(1280, 639, 0,   1, 1, 1, 1, 0, 0);
        vecs[6]  = mk(1282, 640, 0,   1, 1, 1, 0, 0, 0);
        vecs[7]  = mk(1283, 640, 0,   0, 1, 1, 0, 0, 0);
        vecs[8]  = mk(1314, 656, 0,   1, 0, 1, 0, 0, 0);
        vecs[9]  = mk(1504, 751, 0,   1, 0, 1, 0, 0, 0);
        vecs[10] = mk(1506, 752, 0,   1, 1, 1, 0, 0, 0);
        vecs[11] = mk(1600, 799, 0,   1, 1, 1, 0, 0, 0);
        vecs[12] = mk(1602, 0,   1,   1, 1, 1, 1, 1, 0);
        vecs[13] = mk(1603, 0,   1,   0, 1, 1, 1, 0, 0);

        offsets = '{1, 2, 3, 6, 7, 8};

        $display("[TB] reset held");
        repeat (3) @(negedge clk);
        checkOutput("vec_reset_held", obs0, vecs[0].exp);
        #2;
        rstN = 1'b1;

        for (int i = 1; i < 14; i++) begin
            waitClocks(vecs[i].n, $sformatf("vec%0d_reach", i));
            checkOutput($sformatf("vec%0d_n%0d", i, vecs[i].n), obs0, vecs[i].exp);
        end

        // One full default line: period of line_start and hsync width.
        guard = 0;
        while (!ls0 && guard < 4000) begin @(negedge clk); guard++; end
        checkValue("line_start_seen", int'(ls0), 1);
        t0 = n;
        cnt = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (pe0 && !hs0) cnt++;
            guard++;
        end while (!ls0 && guard < 4000);
        checkValue("line_start_period", n - t0, 1600);
        checkValue("hsync_low_pixels", cnt, 96);

        // One full tiny frame: frame period, hsync and vsync pixel counts.
        guard = 0;
        while (!fs1 && guard < 400) begin @(negedge clk); guard++; end
        checkValue("frame_start_seen", int'(fs1), 1);
        t0 = n;
        cnt = 0;
        guard = 0;
        begin
            int vsCnt;
            vsCnt = 0;
            do begin
                @(negedge clk);
                if (!fs1) begin
                    if (pe1 && hs1) cnt++;
                    if (pe1 && vs1) vsCnt++;
                end
                guard++;
            end while (!fs1 && guard < 400);
            if (hs1) cnt++;
            if (vs1) vsCnt++;
            checkValue("tiny_frame_period", n - t0, 98);
            checkValue("tiny_hsync_high_pixels", cnt, 21);
            checkValue("tiny_vsync_high_pixels", vsCnt, 14);
        end

        // Mid-frame asynchronous reset on the default raster at H=300,V=1.
        applyStimulus(2, 3, 0);
        waitClocks(2202, "midframe_reach");
        checkOutput("midframe_pos", obs0, mk(2202, 300, 1, 1, 1, 1, 1, 0, 0).exp);
        applyStimulus(2, 3, 4);

        // Randomised reset timing and run lengths.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(offsets[$urandom_range(0, 5)], $urandom_range(1, 3),
                          $urandom_range(20, 2500));
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
